mm_ln_stream_ingress: RTL and testbench
=======================================

# mm_ln_stream_ingress

Parametrised ingress front-end for the matmul + layer-norm datapath: terminates `N_CH` AXI-stream slave channels (X, W, R, biases, multiplier/exponent tables, etc.) with per-channel 2-entry skid buffers, beat counting against a programmed length, tlast enforcement and completion/error status. It sits between the DMA s2mm ports and the `mm_ln` core, replacing per-channel hand wiring with one vectorised block. The core receives cleaned streams whose tlast is always exactly on the final expected beat.

## Interface
- `N_CH`, 10, number of stream channels
- `D_W_IN`, 32, data width per channel
- `LEN_W`, 16, width of per-channel beat-count registers
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; arms all channels and latches `exp_len`
- `exp_len` in N_CH*LEN_W: expected beats per channel, slice ch at [ch*LEN_W +: LEN_W]
- `s_tdata` in N_CH*D_W_IN; `s_tlast` in N_CH; `s_tvalid` in N_CH; `s_tready` out N_CH: slave streams
- `m_tdata` out N_CH*D_W_IN; `m_tlast` out N_CH; `m_tvalid` out N_CH; `m_tready` in N_CH: master streams to core
- `ch_done` out N_CH: channel finished, all its beats delivered downstream
- `ch_err_early` out N_CH: input tlast seen before the expected final beat
- `ch_err_nolast` out N_CH: final expected beat arrived without input tlast
- `all_done` out 1: AND of `ch_done`
- `busy` out 1: any channel in RUN or DRAIN

## Operation
- Per-channel FSM: IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on next `start`.
- `start` is honoured only when `busy`=0; a pulse while busy is ignored and leaves all state intact.
- On accepted `start`: latch `len[ch]`, clear `cnt[ch]`, `ch_done`, both error flags. If `len`=0, go to DONE directly (`ch_done`=1 next cycle, no beats accepted); otherwise go to RUN.
- RUN: a beat is accepted when `s_tvalid & s_tready`; it is written to the skid buffer and `cnt` increments.
- Final beat = accepted beat with `cnt+1 == len` or with `s_tlast`=1, whichever comes first. Its buffered tlast is forced to 1; all other buffered beats carry tlast=0 regardless of input.
- `s_tlast`=1 with `cnt+1 < len`: set `ch_err_early`. Final beat by count with `s_tlast`=0: set `ch_err_nolast`. Flags are sticky until next accepted `start`.
- After the final beat, go to DRAIN; `s_tready`=0 and further input is not consumed.
- DRAIN -> DONE when the skid buffer is empty; `ch_done` asserts that cycle + 1.
- Skid buffer: 2 entries, FIFO order, no data loss or duplication under any `m_tready` pattern; `m_tdata`/`m_tlast` stable while `m_tvalid & !m_tready`.
- Channels are fully independent; no cross-channel ordering.

## Timing
- Reset: all FSMs IDLE, counters 0, buffers empty; `s_tready`, `m_tvalid`, `m_tlast`, `m_tdata`, `ch_done`, both error vectors, `all_done`, `busy` all 0.
- Reset asserted mid-transfer: in-flight beats discarded immediately; outputs return to reset values asynchronously.
- `s_tready` is registered: high in RUN when buffer occupancy after the current cycle is < 2 and final beat not yet taken. First rise is the cycle after `start`.
- Latency: beat accepted at edge k is on `m_*` with `m_tvalid`=1 after edge k (registered, 1 cycle).
- Throughput: 1 beat/cycle/channel sustained while `m_tready`=1.
- `m_tready` low for any number of cycles: at most 2 beats buffered, `s_tready` drops the cycle after occupancy reaches 2.
- `busy` is high from the cycle after accepted `start` until the last channel reaches DONE; `all_done` rises the same cycle `busy` falls.
- Counter width `LEN_W`; `exp_len` up to 2^LEN_W-1 supported, no wrap within a transfer.

## Test plan
- Normal: `len`=4 on ch0, data 1..4, tlast on 4th, `m_tready`=1 -> m beats 1..4 on consecutive cycles, tlast only on 4, no errors, `ch_done[0]` one cycle after last m handshake.
- Back-pressure: `len`=8, `m_tready` toggles 1/0 each cycle -> 8 beats in order, none lost or repeated, `s_tready` never high with occupancy 2.
- Early tlast: `len`=6, input tlast on beat 3 -> 3 beats out with tlast on 3rd, `ch_err_early`=1, `s_tready` stays 0 afterwards, channel DONE.
- Missing tlast: `len`=3, no input tlast -> 3 beats out, tlast forced on 3rd, `ch_err_nolast`=1, 4th input beat not accepted.
- Zero length + start while busy: ch1 `len`=0, ch0 `len`=5 -> `ch_done[1]`=1 the cycle after start; second `start` during ch0 RUN ignored; `all_done` after ch0 completes.
- Reset mid-run: `rst`=0 after 2 of 5 beats -> all outputs 0 immediately; new `start` with `len`=2 completes cleanly with no stale data.

Source files
------------

// File: rtl/mm_ln_stream_ingress_if.sv
// -----------------------------------------------------------------------------
// mm_ln_stream_ingress_if
// Bundle of the N_CH slave streams (from DMA s2mm) and N_CH master streams
// (to the mm_ln core) handled by mm_ln_stream_ingress. Channel ch occupies
// bit ch of the control vectors and [ch*D_W_IN +: D_W_IN] of the data vectors.
//   slave  : view of the ingress block (consumes s_*, produces m_*)
//   master : view of the surrounding environment (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface mm_ln_stream_ingress_if #(
  parameter int N_CH   = 10,
  parameter int D_W_IN = 32
);
  logic [N_CH*D_W_IN-1:0] s_tdata;
  logic [N_CH-1:0]        s_tlast;
  logic [N_CH-1:0]        s_tvalid;
  logic [N_CH-1:0]        s_tready;

  logic [N_CH*D_W_IN-1:0] m_tdata;
  logic [N_CH-1:0]        m_tlast;
  logic [N_CH-1:0]        m_tvalid;
  logic [N_CH-1:0]        m_tready;

  modport slave (
    input  s_tdata, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tlast, m_tvalid
  );

  modport master (
    output s_tdata, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tvalid
  );
endinterface

// File: rtl/mm_ln_stream_ingress.sv
// -----------------------------------------------------------------------------
// mm_ln_stream_ingress
// Ingress front-end for the matmul + layer-norm core. Each of N_CH stream
// channels gets a 2-entry skid FIFO, a beat counter checked against a length
// latched at start, tlast cleanup (tlast out is exactly on the final beat) and
// sticky completion/error status.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   start         : arm pulse, honoured only while busy = 0
//   exp_len       : expected beats per channel, [ch*LEN_W +: LEN_W]
//   ifc           : slave/master stream bundle (slave modport)
//   ch_done       : channel finished, all beats delivered downstream
//   ch_err_early  : input tlast arrived before the expected final beat
//   ch_err_nolast : final beat by count arrived without input tlast
//   all_done      : AND of ch_done
//   busy          : any channel in RUN or DRAIN
//
// Per-channel FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset, never armed
//   ST_RUN   | accepting input beats until the final beat is taken
//   ST_DRAIN | final beat taken, waiting for the skid FIFO to empty
//   ST_DONE  | all beats delivered; ch_done = 1 until next start
// -----------------------------------------------------------------------------
module mm_ln_stream_ingress #(
  parameter int N_CH   = 10,
  parameter int D_W_IN = 32,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_CH*LEN_W-1:0]   exp_len,
  mm_ln_stream_ingress_if.slave   ifc,
  output logic [N_CH-1:0]         ch_done,
  output logic [N_CH-1:0]         ch_err_early,
  output logic [N_CH-1:0]         ch_err_nolast,
  output logic                    all_done,
  output logic                    busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  logic                   w_start_acc;
  logic [N_CH-1:0]        w_busy_ch;
  logic [N_CH-1:0]        w_s_tready;
  logic [N_CH-1:0]        w_m_tvalid;
  logic [N_CH-1:0]        w_m_tlast;
  logic [N_CH*D_W_IN-1:0] w_m_tdata;

  // All channels are IDLE or DONE whenever busy is low, so an accepted start
  // always finds every channel ready to re-arm.
  assign w_start_acc = start & ~busy;
  assign busy        = |w_busy_ch;
  assign all_done    = &ch_done;

  assign ifc.s_tready = w_s_tready;
  assign ifc.m_tvalid = w_m_tvalid;
  assign ifc.m_tlast  = w_m_tlast;
  assign ifc.m_tdata  = w_m_tdata;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W:0]      w_cnt_inc;
    logic [LEN_W-1:0]    w_len_in;
    logic [1:0]          r_occ;
    logic [1:0]          w_occ_nxt;
    logic [D_W_IN-1:0]   r_data0;
    logic [D_W_IN-1:0]   r_data1;
    logic [D_W_IN-1:0]   w_din;
    logic                r_last0;
    logic                r_last1;
    logic                r_ready;
    logic                r_err_early;
    logic                r_err_nolast;
    logic                w_din_last;
    logic                w_push;
    logic                w_pop;
    logic                w_last_by_cnt;
    logic                w_before_end;
    logic                w_final;

    assign w_len_in   = exp_len[ch*LEN_W +: LEN_W];
    assign w_din      = ifc.s_tdata[ch*D_W_IN +: D_W_IN];
    assign w_din_last = ifc.s_tlast[ch];

    // r_ready is only ever high in RUN, so it alone qualifies a push.
    assign w_push = r_ready & ifc.s_tvalid[ch];
    assign w_pop  = (r_occ != 2'd0) & ifc.m_tready[ch];

    // One extra bit keeps the compare exact even for len = 2^LEN_W-1.
    assign w_cnt_inc     = {1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign w_last_by_cnt = (w_cnt_inc == {1'b0, r_len});
    assign w_before_end  = (w_cnt_inc <  {1'b0, r_len});
    assign w_final       = w_push & (w_last_by_cnt | w_din_last);

    assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_acc) begin
            w_state_nxt = (w_len_in == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_final) begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_occ == 2'd0) begin
            w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state      <= ST_IDLE;
        r_len        <= '0;
        r_cnt        <= '0;
        r_occ        <= 2'd0;
        r_data0      <= '0;
        r_data1      <= '0;
        r_last0      <= 1'b0;
        r_last1      <= 1'b0;
        r_ready      <= 1'b0;
        r_err_early  <= 1'b0;
        r_err_nolast <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_occ   <= w_occ_nxt;
        // Looks at post-edge occupancy so s_tready can never be high while
        // both entries are full.
        r_ready <= (w_state_nxt == ST_RUN) && (w_occ_nxt != 2'd2);

        if (w_start_acc) begin
          r_len        <= w_len_in;
          r_cnt        <= '0;
          r_err_early  <= 1'b0;
          r_err_nolast <= 1'b0;
        end else if (w_push) begin
          r_cnt <= w_cnt_inc[LEN_W-1:0];
          if (w_din_last && w_before_end) begin
            r_err_early <= 1'b1;
          end
          if (!w_din_last && w_last_by_cnt) begin
            r_err_nolast <= 1'b1;
          end
        end

        // Head entry drives m_*; shift only when the second entry is valid.
        if (w_pop && (r_occ == 2'd2)) begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
        end
        // Write slot is the occupancy left after this edge's pop; this later
        // assignment wins over the shift when both target the head.
        if (w_push) begin
          if ((r_occ - {1'b0, w_pop}) == 2'd0) begin
            r_data0 <= w_din;
            r_last0 <= w_final;
          end else begin
            r_data1 <= w_din;
            r_last1 <= w_final;
          end
        end
      end
    end

    assign w_s_tready[ch]                   = r_ready;
    assign w_m_tvalid[ch]                   = (r_occ != 2'd0);
    assign w_m_tlast[ch]                    = r_last0 & (r_occ != 2'd0);
    assign w_m_tdata[ch*D_W_IN +: D_W_IN]   = r_data0;
    assign w_busy_ch[ch]                    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign ch_done[ch]                      = (r_state == ST_DONE);
    assign ch_err_early[ch]                 = r_err_early;
    assign ch_err_nolast[ch]                = r_err_nolast;
  end

endmodule

// File: tb/tb_mm_ln_stream_ingress.sv
// -----------------------------------------------------------------------------
// tb_mm_ln_stream_ingress
// Directed bench for mm_ln_stream_ingress with two channels. Channel 0 carries
// the traffic; channel 1 is used for the zero-length case.
// -----------------------------------------------------------------------------
module tb_mm_ln_stream_ingress;
  localparam int N_CH   = 2;
  localparam int D_W_IN = 32;
  localparam int LEN_W  = 16;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [N_CH*LEN_W-1:0] exp_len;
  logic [N_CH-1:0]       ch_done;
  logic [N_CH-1:0]       ch_err_early;
  logic [N_CH-1:0]       ch_err_nolast;
  logic                  all_done;
  logic                  busy;

  int total;
  int bad;

  mm_ln_stream_ingress_if #(.N_CH(N_CH), .D_W_IN(D_W_IN)) ifc ();

  mm_ln_stream_ingress #(.N_CH(N_CH), .D_W_IN(D_W_IN), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .exp_len       (exp_len),
    .ifc           (ifc),
    .ch_done       (ch_done),
    .ch_err_early  (ch_err_early),
    .ch_err_nolast (ch_err_nolast),
    .all_done      (all_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat on ch0 with m_tready[0]=1: checks it was offered ready, then
  // that it shows up on m_* right after the edge.
  task automatic beat(input string tag, input logic [31:0] d, input logic lst,
                      input logic exp_last, input logic exp_rdy);
    chk({tag, "_rdy_before"}, ifc.s_tready[0], 1);
    ifc.s_tvalid[0]    = 1'b1;
    ifc.s_tdata[31:0]  = d;
    ifc.s_tlast[0]     = lst;
    tick();
    chk({tag, "_mvalid"}, ifc.m_tvalid[0], 1);
    chk({tag, "_mdata"},  ifc.m_tdata[31:0], d);
    chk({tag, "_mlast"},  ifc.m_tlast[0], exp_last);
    chk({tag, "_rdy_after"}, ifc.s_tready[0], exp_rdy);
    ifc.s_tvalid[0] = 1'b0;
    ifc.s_tlast[0]  = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] len1, input logic [15:0] len0);
    exp_len = {len1, len0};
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    int sent;
    int got;
    int occ;
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    start         = 1'b0;
    exp_len       = '0;
    ifc.s_tdata   = '0;
    ifc.s_tlast   = '0;
    ifc.s_tvalid  = '0;
    ifc.m_tready  = '1;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_s_tready", ifc.s_tready, 0);
    chk("rst_m_tvalid", ifc.m_tvalid, 0);
    chk("rst_m_tlast",  ifc.m_tlast, 0);
    chk("rst_m_tdata",  ifc.m_tdata, 0);
    chk("rst_ch_done",  ch_done, 0);
    chk("rst_errs",     {ch_err_early, ch_err_nolast}, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_busy",     busy, 0);
    rst = 1'b1;
    tick();

    // ---- normal: len 4, data 1..4 ----
    pulse_start(16'd0, 16'd4);
    chk("n_start_rdy",  ifc.s_tready[0], 1);
    chk("n_start_busy", busy, 1);
    chk("n_start_done", ch_done, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      beat("n_beat", i, (i == 4), (i == 4), (i < 4));
    end
    tick();
    chk("n_drain_mvalid", ifc.m_tvalid[0], 0);
    chk("n_drain_done",   ch_done[0], 0);
    tick();
    chk("n_done",     ch_done, 2'b11);
    chk("n_busy",     busy, 0);
    chk("n_all_done", all_done, 1);
    chk("n_errs",     {ch_err_early, ch_err_nolast}, 0);

    // ---- back-pressure: len 8, m_tready toggles ----
    pulse_start(16'd0, 16'd8);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      ifc.s_tvalid[0]   = (sent < 8);
      ifc.s_tdata[31:0] = 32'h100 + sent;
      ifc.s_tlast[0]    = (sent == 7);
      ifc.m_tready[0]   = ((cyc % 2) == 1);
      #1;
      occ = sent - got;
      chk("bp_mvalid_occ", ifc.m_tvalid[0], (occ != 0));
      chk("bp_rdy_full",   ifc.s_tready[0] & (occ == 2), 0);
      if (ifc.m_tvalid[0] && ifc.m_tready[0]) begin
        chk("bp_mdata", ifc.m_tdata[31:0], 32'h100 + got);
        chk("bp_mlast", ifc.m_tlast[0], (got == 7));
        got++;
      end
      if (ifc.s_tready[0] && ifc.s_tvalid[0]) sent++;
      tick();
    end
    chk("bp_got_all", got, 8);
    chk("bp_sent_all", sent, 8);
    ifc.s_tvalid[0] = 1'b0;
    ifc.s_tlast[0]  = 1'b0;
    ifc.m_tready[0] = 1'b1;
    tick();
    tick();
    chk("bp_done", ch_done, 2'b11);
    chk("bp_errs", {ch_err_early, ch_err_nolast}, 0);

    // ---- early tlast: len 6, tlast on beat 3 ----
    pulse_start(16'd0, 16'd6);
    beat("e_b1", 32'h11, 1'b0, 1'b0, 1'b1);
    beat("e_b2", 32'h12, 1'b0, 1'b0, 1'b1);
    beat("e_b3", 32'h13, 1'b1, 1'b1, 1'b0);
    chk("e_err_early_now", ch_err_early[0], 1);
    ifc.s_tvalid[0]   = 1'b1;
    ifc.s_tdata[31:0] = 32'hAA;
    tick();
    chk("e_rdy_low1", ifc.s_tready[0], 0);
    chk("e_mvalid0",  ifc.m_tvalid[0], 0);
    tick();
    chk("e_done",       ch_done[0], 1);
    chk("e_err_early",  ch_err_early[0], 1);
    chk("e_err_nolast", ch_err_nolast[0], 0);
    chk("e_rdy_low2",   ifc.s_tready[0], 0);
    tick();
    chk("e_no_consume", ifc.m_tvalid[0], 0);
    ifc.s_tvalid[0] = 1'b0;

    // ---- missing tlast: len 3 ----
    pulse_start(16'd0, 16'd3);
    chk("m_err_cleared", {ch_err_early[0], ch_err_nolast[0]}, 0);
    beat("m_b1", 32'h21, 1'b0, 1'b0, 1'b1);
    beat("m_b2", 32'h22, 1'b0, 1'b0, 1'b1);
    beat("m_b3", 32'h23, 1'b0, 1'b1, 1'b0);
    ifc.s_tvalid[0]   = 1'b1;
    ifc.s_tdata[31:0] = 32'h24;
    tick();
    chk("m_4th_rejected", ifc.m_tvalid[0], 0);
    tick();
    chk("m_done",       ch_done[0], 1);
    chk("m_err_nolast", ch_err_nolast[0], 1);
    chk("m_err_early",  ch_err_early[0], 0);
    ifc.s_tvalid[0] = 1'b0;

    // ---- zero length on ch1 + start while busy ----
    pulse_start(16'd0, 16'd5);
    chk("z_ch1_done", ch_done, 2'b10);
    chk("z_busy",     busy, 1);
    beat("z_b1", 32'h31, 1'b0, 1'b0, 1'b1);
    beat("z_b2", 32'h32, 1'b0, 1'b0, 1'b1);
    pulse_start(16'd7, 16'd2);
    chk("z_ign_done",   ch_done, 2'b10);
    chk("z_ign_busy",   busy, 1);
    chk("z_ign_mvalid", ifc.m_tvalid[0], 0);
    chk("z_ign_rdy",    ifc.s_tready[0], 1);
    beat("z_b3", 32'h33, 1'b0, 1'b0, 1'b1);
    beat("z_b4", 32'h34, 1'b0, 1'b0, 1'b1);
    beat("z_b5", 32'h35, 1'b1, 1'b1, 1'b0);
    tick();
    chk("z_drain_all_done", all_done, 0);
    chk("z_drain_busy",     busy, 1);
    tick();
    chk("z_all_done", all_done, 1);
    chk("z_busy_end", busy, 0);
    chk("z_errs",     {ch_err_early, ch_err_nolast}, 0);

    // ---- reset mid-run ----
    pulse_start(16'd0, 16'd5);
    beat("r_b1", 32'h41, 1'b0, 1'b0, 1'b1);
    beat("r_b2", 32'h42, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk("r_async_mvalid", ifc.m_tvalid, 0);
    chk("r_async_mdata",  ifc.m_tdata, 0);
    chk("r_async_mlast",  ifc.m_tlast, 0);
    chk("r_async_rdy",    ifc.s_tready, 0);
    chk("r_async_busy",   busy, 0);
    chk("r_async_done",   {all_done, ch_done}, 0);
    tick();
    rst = 1'b1;
    tick();
    pulse_start(16'd0, 16'd2);
    chk("r2_no_stale_v", ifc.m_tvalid[0], 0);
    chk("r2_no_stale_d", ifc.m_tdata[31:0], 0);
    beat("r2_b1", 32'h55, 1'b0, 1'b0, 1'b1);
    beat("r2_b2", 32'h66, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk("r2_done", ch_done, 2'b11);
    chk("r2_errs", {ch_err_early, ch_err_nolast}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
